// File: rtl/wb_serial_tx_pkg.sv
// Shared constants, register map and FSM states for wb_serial_tx.
// Imported by the interface-facing top and by the serial core.
package wb_serial_tx_pkg;

  localparam int WORD_W_DEF = 10;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_TXDATA = 8'h04;
  localparam logic [7:0] ADDR_STATUS = 8'h08;

  localparam int CTRL_DIV_LSB = 0;
  localparam int CTRL_NW_LSB  = 8;
  localparam int CTRL_START   = 16;
  localparam int CTRL_PAT     = 17;

  localparam int ST_BUSY    = 0;
  localparam int ST_ERR     = 1;
  localparam int ST_REM_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SHIFT
  } tx_state_t;

endpackage

// File: rtl/wb_serial_tx_if.sv
// Wishbone B4 classic bus bundle (initiator -> responder).
// Ports: CYC_I, STB_I, WE_I, ADR_I, DAT_I in; DAT_O, ACK_O out (slave view).
interface wb_serial_tx_if #(
  parameter int ADR_W = 32,
  parameter int DAT_W = 32
);
  logic             CYC_I;
  logic             STB_I;
  logic             WE_I;
  logic [ADR_W-1:0] ADR_I;
  logic [DAT_W-1:0] DAT_I;
  logic [DAT_W-1:0] DAT_O;
  logic             ACK_O;

  modport master (
    output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/serial_tx_core.sv
// Serial burst engine: start marker, then NWORDS words LSB first.
// Ports: clk, rst, i_start/i_clkdiv/i_nwords/i_pattern/i_seed in; o_busy, o_ena, o_data, o_words_rem out.
module serial_tx_core
  import wb_serial_tx_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_clkdiv,
  input  logic [7:0]        i_nwords,
  input  logic              i_pattern,
  input  logic [WORD_W-1:0] i_seed,
  output logic              o_busy,
  output logic              o_ena,
  output logic              o_data,
  output logic [7:0]        o_words_rem
);

  localparam int BW = $clog2(WORD_W);
  localparam logic [BW-1:0] LAST = BW'(WORD_W - 1);

  tx_state_t r_state, w_state;
  logic [7:0] r_div, w_div;
  logic [7:0] r_words, w_words;
  logic [BW-1:0] r_bit, w_bit;
  logic [WORD_W-1:0] r_shift, w_shift;
  logic [WORD_W-1:0] r_word, w_word;
  logic [WORD_W-1:0] w_next;
  logic r_ena, w_ena;
  logic r_data, w_data;
  logic w_tick;

  assign w_tick = (r_div == i_clkdiv);
  // Incrementing pattern wraps naturally at WORD_W bits.
  assign w_next = i_pattern ? r_word + WORD_W'(1) : r_word;

  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_words = r_words;
    w_bit   = r_bit;
    w_shift = r_shift;
    w_word  = r_word;
    w_ena   = r_ena;
    w_data  = r_data;
    unique case (r_state)
      IDLE: begin
        if (i_start && i_nwords != 8'd0) begin
          w_state = MARK;
          w_ena   = 1'b1;
          w_div   = 8'd0;
          w_words = i_nwords;
          w_word  = i_seed;
          w_shift = i_seed;
          w_bit   = '0;
          w_data  = 1'b0;
        end
      end
      MARK: begin
        w_div = r_div + 8'd1;
        if (w_tick) begin
          w_state = SHIFT;
          w_div   = 8'd0;
          w_ena   = 1'b0;
          w_data  = r_shift[0];
          w_shift = r_shift >> 1;
          w_bit   = '0;
        end
      end
      SHIFT: begin
        w_div = r_div + 8'd1;
        if (w_tick) begin
          w_div = 8'd0;
          if (r_bit == LAST) begin
            w_words = r_words - 8'd1;
            if (r_words == 8'd1) begin
              w_state = IDLE;
              w_data  = 1'b0;
            end else begin
              // Next word goes straight out, no idle bit between words.
              w_word  = w_next;
              w_data  = w_next[0];
              w_shift = w_next >> 1;
              w_bit   = '0;
            end
          end else begin
            w_bit   = r_bit + BW'(1);
            w_data  = r_shift[0];
            w_shift = r_shift >> 1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_div   <= '0;
      r_words <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_word  <= '0;
      r_ena   <= 1'b0;
      r_data  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_words <= w_words;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_word  <= w_word;
      r_ena   <= w_ena;
      r_data  <= w_data;
    end
  end

  assign o_busy      = (r_state != IDLE);
  assign o_ena       = r_ena;
  assign o_data      = r_data;
  assign o_words_rem = r_words;

endmodule

// File: rtl/wb_serial_tx.sv
// Wishbone classic slave: CTRL/TXDATA/STATUS registers driving the serial core.
// Ports: CLK_I, RST_I; wb (slave modport); ena_o start marker; data_o serial data.
module wb_serial_tx
  import wb_serial_tx_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int ADR_W  = 32,
  parameter int DAT_W  = 32
) (
  input  logic CLK_I,
  input  logic RST_I,
  wb_serial_tx_if.slave wb,
  output logic ena_o,
  output logic data_o
);

  logic r_acked, r_ack, r_start, r_pat, r_err;
  logic [7:0] r_clkdiv, r_nw;
  logic [WORD_W-1:0] r_seed;
  logic [DAT_W-1:0] r_dat;
  logic [DAT_W-1:0] w_rdata;
  logic [7:0] w_rem;
  logic [5:0] w_reg;
  logic w_req, w_wr, w_busy, w_busy_any;
  logic w_sel_ctrl, w_sel_tx, w_sel_st;
  logic w_unused;

  // One access per strobe: re-arm only once the initiator drops STB/CYC.
  assign w_req = wb.CYC_I & wb.STB_I & ~r_acked;
  assign w_wr  = w_req & wb.WE_I;
  assign w_reg = wb.ADR_I[7:2];

  assign w_sel_ctrl = (w_reg == ADDR_CTRL[7:2]);
  assign w_sel_tx   = (w_reg == ADDR_TXDATA[7:2]);
  assign w_sel_st   = (w_reg == ADDR_STATUS[7:2]);

  // A launch still in flight counts as busy for write rejection.
  assign w_busy_any = w_busy | r_start;

  assign w_unused = &{1'b0, wb.ADR_I[ADR_W-1:8], wb.ADR_I[1:0],
                      wb.DAT_I[DAT_W-1:CTRL_PAT+1]};

  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      w_sel_ctrl: begin
        w_rdata[CTRL_DIV_LSB +: 8] = r_clkdiv;
        w_rdata[CTRL_NW_LSB +: 8]  = r_nw;
        w_rdata[CTRL_PAT]          = r_pat;
      end
      w_sel_tx: w_rdata[WORD_W-1:0] = r_seed;
      w_sel_st: begin
        w_rdata[ST_BUSY]          = w_busy;
        w_rdata[ST_ERR]           = r_err;
        w_rdata[ST_REM_LSB +: 8]  = w_rem;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      r_acked  <= 1'b0;
      r_ack    <= 1'b0;
      r_start  <= 1'b0;
      r_pat    <= 1'b0;
      r_err    <= 1'b0;
      r_clkdiv <= '0;
      r_nw     <= '0;
      r_seed   <= '0;
      r_dat    <= '0;
    end else begin
      r_ack   <= w_req;
      r_start <= 1'b0;
      if (!(wb.CYC_I && wb.STB_I)) r_acked <= 1'b0;
      else if (w_req)              r_acked <= 1'b1;
      r_dat <= (w_req && !wb.WE_I) ? w_rdata : '0;
      if (w_wr) begin
        unique case (1'b1)
          w_sel_ctrl: begin
            if (w_busy_any) r_err <= 1'b1;
            else begin
              r_clkdiv <= wb.DAT_I[CTRL_DIV_LSB +: 8];
              r_nw     <= wb.DAT_I[CTRL_NW_LSB +: 8];
              r_pat    <= wb.DAT_I[CTRL_PAT];
              r_start  <= wb.DAT_I[CTRL_START] &
                          (wb.DAT_I[CTRL_NW_LSB +: 8] != 8'd0);
            end
          end
          w_sel_tx: begin
            if (w_busy_any) r_err <= 1'b1;
            else r_seed <= wb.DAT_I[WORD_W-1:0];
          end
          w_sel_st: if (wb.DAT_I[ST_ERR]) r_err <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign wb.ACK_O = r_ack;
  assign wb.DAT_O = r_dat;

  serial_tx_core #(.WORD_W(WORD_W)) u_core (
    .clk        (CLK_I),
    .rst        (RST_I),
    .i_start    (r_start),
    .i_clkdiv   (r_clkdiv),
    .i_nwords   (r_nw),
    .i_pattern  (r_pat),
    .i_seed     (r_seed),
    .o_busy     (w_busy),
    .o_ena      (ena_o),
    .o_data     (data_o),
    .o_words_rem(w_rem)
  );

endmodule

// File: tb/tb_wb_serial_tx.sv
// Bench for wb_serial_tx: register table, serial scoreboard, busy/err/reset sequences.
// Drives the Wishbone interface and decodes ena_o/data_o into words.
module tb_wb_serial_tx;

  localparam int WORD_W = 10;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_TX   = 32'h04;
  localparam logic [31:0] A_ST   = 32'h08;

  logic clk, rst, ena_o, data_o;
  wb_serial_tx_if #(.ADR_W(32), .DAT_W(32)) bus ();

  wb_serial_tx #(.WORD_W(WORD_W), .ADR_W(32), .DAT_W(32)) dut (
    .CLK_I (clk),
    .RST_I (rst),
    .wb    (bus.slave),
    .ena_o (ena_o),
    .data_o(data_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
  endtask

  // Scoreboard and serial monitor
  logic [WORD_W-1:0] exp_q[$];
  int period = 1;
  int frame_words = 1;
  int words_seen = 0;
  int ena_rises = 0;
  int data_toggles = 0;
  int fall_cyc = 0;
  bit fall_seen = 0;
  int mon_phase = 0;
  int mon_cnt = 0;
  int mon_pos = 0;
  int mon_fw = 0;
  logic [WORD_W-1:0] mon_word = '0;
  logic prev_data = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mon_phase = 0;
    end else begin
      if (data_o !== prev_data) data_toggles++;
      if (mon_phase == 1 && !ena_o) begin
        check("ena_width", mon_cnt, period);
        mon_phase = 2;
        mon_pos = 0;
        mon_word = '0;
        mon_fw = 0;
        fall_cyc = cyc;
        fall_seen = 1;
      end
      if (mon_phase == 0 && ena_o) begin
        ena_rises++;
        mon_phase = 1;
        mon_cnt = 0;
      end
      if (mon_phase == 1) begin
        mon_cnt++;
      end else if (mon_phase == 2) begin
        if (mon_pos % period == period / 2)
          mon_word[mon_pos / period] = data_o;
        if (mon_pos == WORD_W * period - 1) begin
          if (exp_q.size() == 0) check("unexpected_word", 32'(mon_word), 32'hFFFF_FFFF);
          else check("serial_word", 32'(mon_word), 32'(exp_q.pop_front()));
          words_seen++;
          mon_fw++;
          mon_pos = 0;
          mon_word = '0;
          if (mon_fw == frame_words) mon_phase = 0;
        end else begin
          mon_pos++;
        end
      end
    end
    prev_data = data_o;
  end

  // Bus access; caller is aligned 1 ns after a rising edge.
  task automatic wb_acc(input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input int hold,
                        output logic [31:0] rd);
    int acks = 0;
    int lat = -1;
    rd = '0;
    bus.CYC_I = 1'b1;
    bus.STB_I = 1'b1;
    bus.WE_I  = we;
    bus.ADR_I = adr;
    bus.DAT_I = dat;
    for (int n = 0; n < 8 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (bus.ACK_O) begin acks++; lat = n; rd = bus.DAT_O; end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (bus.ACK_O) acks++;
    end
    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    @(posedge clk); #1;
    if (bus.ACK_O) acks++;
    check("ack_count", acks, 1);
    check("ack_latency", lat, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int hold);
    logic [31:0] dummy;
    wb_acc(1'b1, a, d, hold, dummy);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    wb_acc(1'b0, a, 32'h0, 0, v);
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    while (words_seen < n && c < budget) begin @(posedge clk); #1; c++; end
    check("words_done", words_seen, n);
  endtask

  task automatic wait_fall(input int budget);
    int c = 0;
    while (!fall_seen && c < budget) begin @(posedge clk); #1; c++; end
    check("frame_start", 32'(fall_seen), 1);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic [31:0] v;
    int r0, t0;

    tbl[0]  = '{1'b1, A_TX,   32'hFFFF_FFFF, 32'h0};
    tbl[1]  = '{1'b0, A_TX,   32'h0,         32'h0000_03FF};
    tbl[2]  = '{1'b1, A_CTRL, 32'h0002_0305, 32'h0};
    tbl[3]  = '{1'b0, A_CTRL, 32'h0,         32'h0002_0305};
    tbl[4]  = '{1'b1, 32'h44, 32'hFFFF_FFFF, 32'h0};
    tbl[5]  = '{1'b0, 32'h44, 32'h0,         32'h0};
    tbl[6]  = '{1'b0, 32'h40, 32'h0,         32'h0};
    tbl[7]  = '{1'b0, A_CTRL, 32'h0,         32'h0002_0305};
    tbl[8]  = '{1'b1, A_CTRL, 32'h0001_0007, 32'h0};
    tbl[9]  = '{1'b0, A_CTRL, 32'h0,         32'h0000_0007};
    tbl[10] = '{1'b0, A_ST,   32'h0,         32'h0};

    bus.CYC_I = 1'b0;
    bus.STB_I = 1'b0;
    bus.WE_I  = 1'b0;
    bus.ADR_I = '0;
    bus.DAT_I = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.ACK_O), 0);
    check("rst_dat", bus.DAT_O, 0);
    check("rst_ena", 32'(ena_o), 0);
    check("rst_data", 32'(data_o), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Register table, includes START with NWORDS=0 and unmapped accesses
    for (int i = 0; i < 11; i++) begin
      wb_acc(tbl[i].we, tbl[i].adr, tbl[i].dat, 0, v);
      if (!tbl[i].we) check($sformatf("tbl%0d", i), v, tbl[i].exp);
    end
    repeat (10) @(posedge clk);
    #1;
    check("nw0_no_frame", ena_rises, 0);

    // Two incrementing words, CLKDIV=1, strobe held past ACK
    period = 2; frame_words = 2; words_seen = 0; fall_seen = 0;
    wr(A_TX, 32'h155, 0);
    exp_q.push_back(10'h155);
    exp_q.push_back(10'h156);
    wr(A_CTRL, 32'h0003_0201, 1);
    wait_fall(50);
    while (cyc < fall_cyc + 39) begin @(posedge clk); #1; end
    rd(A_ST, v);
    check("busy_at_800ns", 32'(v[0]), 1);
    rd(A_ST, v);
    check("busy_after_800ns", 32'(v[0]), 0);
    check("t2_words", words_seen, 2);
    rd(A_CTRL, v);
    check("ctrl_start_reads0", v, 32'h0002_0201);
    rd(A_ST, v);
    check("t2_status", v, 0);

    // Wrap 3FF -> 000, one clock per bit
    period = 1; frame_words = 3; words_seen = 0; fall_seen = 0;
    wr(A_TX, 32'h3FF, 0);
    exp_q.push_back(10'h3FF);
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h001);
    wr(A_CTRL, 32'h0003_0300, 0);
    wait_words(3, 200);
    rd(A_ST, v);
    check("t3_status", v, 0);

    // Writes while busy are discarded and flag err
    period = 4; frame_words = 2; words_seen = 0; fall_seen = 0;
    wr(A_TX, 32'h0A5, 0);
    exp_q.push_back(10'h0A5);
    exp_q.push_back(10'h0A5);
    r0 = ena_rises;
    wr(A_CTRL, 32'h0001_0203, 0);
    wait_fall(50);
    wr(A_CTRL, 32'h0003_0105, 0);
    wr(A_TX, 32'h111, 0);
    rd(A_ST, v);
    check("busy_err", v & 32'h3, 32'h3);
    rd(A_CTRL, v);
    check("ctrl_kept", v, 32'h0000_0203);
    rd(A_TX, v);
    check("seed_kept", v, 32'h0A5);
    wait_words(2, 300);
    repeat (4) @(posedge clk);
    #1;
    check("one_frame", ena_rises, r0 + 1);
    rd(A_ST, v);
    check("err_sticky", v, 32'h2);
    wr(A_ST, 32'h2, 0);
    rd(A_ST, v);
    check("err_cleared", v, 0);

    // Reset mid-frame
    period = 2; frame_words = 4; words_seen = 0; fall_seen = 0;
    wr(A_TX, 32'h3FF, 0);
    wr(A_CTRL, 32'h0001_0401, 0);
    wait_fall(50);
    repeat (5) @(posedge clk);
    #5;
    check("pre_rst_data", 32'(data_o), 1);
    rst = 1'b1;
    #1;
    check("rst_mid_data", 32'(data_o), 0);
    check("rst_mid_ena", 32'(ena_o), 0);
    check("rst_mid_ack", 32'(bus.ACK_O), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd(A_ST, v);
    check("post_rst_status", v, 0);
    rd(A_CTRL, v);
    check("post_rst_ctrl", v, 0);
    r0 = ena_rises;
    t0 = data_toggles;
    repeat (60) @(posedge clk);
    #1;
    check("post_rst_no_ena", ena_rises, r0);
    check("post_rst_no_data", data_toggles, t0);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
